// File: rtl/preg_free_list.sv
// preg_free_list
//   Physical-register free list for a 2-wide rename path. Circular FIFO of
//   DEPTH entries with show-ahead outputs: up to two pops (rename) and two
//   pushes (retire) per cycle. At reset the list holds pregs
//   NUM_AREGS..NUM_PREGS-1, because the low pregs carry the initial
//   architectural mappings.
//
// Ports
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_alloc_req[0:1]        rename consumes o_free_pregs[k] this cycle
//   o_free_pregs[0:1]       next two free pregs, FIFO order (show-ahead)
//   o_free_valid[0:1]       o_free_pregs[k] is valid
//   i_release_en[0:1]       retire returns i_release_preg[k]
//   i_release_preg[0:1]     preg being returned
//   o_free_count            current occupancy
//   o_alloc_err             one-cycle pulse after an illegal alloc request
//   o_overflow              sticky, set when a release had to be dropped
module preg_free_list #(
   parameter int NUM_PREGS = 64,
   parameter int NUM_AREGS = 32,
   parameter int PREG_W    = 6,
   parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_alloc_req    [0:1],
   output logic [PREG_W-1:0] o_free_pregs   [0:1],
   output logic              o_free_valid   [0:1],
   input  logic              i_release_en   [0:1],
   input  logic [PREG_W-1:0] i_release_preg [0:1],
   output logic [CNT_W-1:0]  o_free_count,
   output logic              o_alloc_err,
   output logic              o_overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PREG_W-1:0] entry_q [DEPTH];
   logic [PREG_W-1:0] entry_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              alloc_err_q, alloc_err_d;
   logic              overflow_q, overflow_d;

   logic [PTR_W-1:0]  head_p1;
   logic              valid0, valid1;
   logic [1:0]        pop_n;
   logic [1:0]        push_n;
   logic              rel0, rel1, acc0, acc1;
   logic [CNT_W-1:0]  avail;
   logic [CNT_W-1:0]  space;

   // Modulo-DEPTH pointer advance; DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [1:0] n);
      logic [PTR_W:0] s;
      s = {1'b0, p} + (PTR_W+1)'(n);
      if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
      return s[PTR_W-1:0];
   endfunction

   assign head_p1 = ptr_add(head_q, 2'd1);
   assign valid0  = (count_q != '0);
   assign valid1  = (count_q >= CNT_W'(2));

   assign o_free_pregs[0] = entry_q[head_q];
   assign o_free_pregs[1] = entry_q[head_p1];
   assign o_free_valid[0] = valid0;
   assign o_free_valid[1] = valid1;
   assign o_free_count    = count_q;
   assign o_alloc_err     = alloc_err_q;
   assign o_overflow      = overflow_q;

   always_comb begin
      pop_n = 2'd0;
      if (i_alloc_req[0] && i_alloc_req[1] && valid1)
         pop_n = 2'd2;
      else if (i_alloc_req[0] && valid0)
         pop_n = 2'd1;

      // Port 1 alone is out of order; any request on an empty slot is unserved.
      alloc_err_d = (i_alloc_req[1] && !i_alloc_req[0]) ||
                    (i_alloc_req[0] && !valid0) ||
                    (i_alloc_req[1] && !valid1);

      // p0 is the hardwired zero register and never enters the list.
      rel0 = i_release_en[0] && (i_release_preg[0] != '0);
      rel1 = i_release_en[1] && (i_release_preg[1] != '0);

      // Room is judged after this cycle's pops; port 1 is dropped first.
      avail = count_q - CNT_W'(pop_n);
      space = CNT_W'(DEPTH) - avail;
      acc0  = rel0 && (space != '0);
      acc1  = rel1 && (space > CNT_W'(acc0));

      overflow_d = overflow_q || (rel0 && !acc0) || (rel1 && !acc1);

      entry_d = entry_q;
      tail_d  = tail_q;
      if (acc0) begin
         entry_d[tail_d] = i_release_preg[0];
         tail_d          = ptr_add(tail_d, 2'd1);
      end
      if (acc1) begin
         entry_d[tail_d] = i_release_preg[1];
         tail_d          = ptr_add(tail_d, 2'd1);
      end
      push_n = {1'b0, acc0} + {1'b0, acc1};

      head_d  = ptr_add(head_q, pop_n);
      count_d = avail + CNT_W'(push_n);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++)
            entry_q[i] <= PREG_W'(NUM_AREGS + i);
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= CNT_W'(DEPTH);
         alloc_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         entry_q     <= entry_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         alloc_err_q <= alloc_err_d;
         overflow_q  <= overflow_d;
      end
   end

endmodule

// File: tb/tb_preg_free_list.sv
module tb_preg_free_list;

   localparam int DEPTH = 32;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             alloc_req    [0:1];
   logic [5:0]       free_pregs   [0:1];
   logic             free_valid   [0:1];
   logic             release_en   [0:1];
   logic [5:0]       release_preg [0:1];
   logic [CNT_W-1:0] free_count;
   logic             alloc_err;
   logic             overflow;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int q[$];
   bit exp_ovf;

   preg_free_list dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_alloc_req    (alloc_req),
      .o_free_pregs   (free_pregs),
      .o_free_valid   (free_valid),
      .i_release_en   (release_en),
      .i_release_preg (release_preg),
      .o_free_count   (free_count),
      .o_alloc_err    (alloc_err),
      .o_overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_req[0]    = 1'b0; alloc_req[1]    = 1'b0;
      release_en[0]   = 1'b0; release_en[1]   = 1'b0;
      release_preg[0] = '0;   release_preg[1] = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      q.delete();
      for (int i = 0; i < DEPTH; i++) q.push_back(32 + i);
      exp_ovf = 1'b0;
   endtask

   // One clock with the given stimulus. Show-ahead outputs are checked
   // against the reference queue before the edge, flags after it.
   task automatic mcycle(input string tag, input bit r0, input bit r1,
                         input bit e0, input logic [5:0] p0,
                         input bit e1, input logic [5:0] p1);
      int size_before;
      int pop_n;
      bit exp_err;
      size_before = q.size();
      chk({tag, "_count"}, 32'(free_count), size_before);
      chk({tag, "_valid0"}, 32'(free_valid[0]), 32'(size_before >= 1));
      chk({tag, "_valid1"}, 32'(free_valid[1]), 32'(size_before >= 2));
      if (size_before >= 1) chk({tag, "_preg0"}, 32'(free_pregs[0]), q[0]);
      if (size_before >= 2) chk({tag, "_preg1"}, 32'(free_pregs[1]), q[1]);
      alloc_req[0] = r0; alloc_req[1] = r1;
      release_en[0] = e0; release_preg[0] = p0;
      release_en[1] = e1; release_preg[1] = p1;
      step();
      idle_inputs();
      if (r0 && r1 && size_before >= 2) pop_n = 2;
      else if (r0 && size_before >= 1)  pop_n = 1;
      else                              pop_n = 0;
      repeat (pop_n) void'(q.pop_front());
      if (e0 && p0 != 0) begin
         if (q.size() < DEPTH) q.push_back(int'(p0));
         else exp_ovf = 1'b1;
      end
      if (e1 && p1 != 0) begin
         if (q.size() < DEPTH) q.push_back(int'(p1));
         else exp_ovf = 1'b1;
      end
      exp_err = (r1 && !r0) || (r0 && size_before < 1) || (r1 && size_before < 2);
      chk({tag, "_alloc_err"}, 32'(alloc_err), 32'(exp_err));
      chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
   endtask

   initial begin
      int a;
      do_reset();

      // Reset state
      chk("rst_preg0", 32'(free_pregs[0]), 32);
      chk("rst_preg1", 32'(free_pregs[1]), 33);
      chk("rst_valid0", 32'(free_valid[0]), 1);
      chk("rst_valid1", 32'(free_valid[1]), 1);
      chk("rst_count", 32'(free_count), 32);
      chk("rst_alloc_err", 32'(alloc_err), 0);
      chk("rst_overflow", 32'(overflow), 0);

      // Drain the full list two at a time
      for (int i = 0; i < 16; i++) mcycle("drain", 1, 1, 0, 0, 0, 0);
      chk("drained_count", 32'(free_count), 0);
      chk("drained_valid0", 32'(free_valid[0]), 0);
      chk("drained_valid1", 32'(free_valid[1]), 0);
      mcycle("empty_req", 1, 0, 0, 0, 0, 0);
      chk("empty_err_pulse", 32'(alloc_err), 1);
      mcycle("after_err", 0, 0, 0, 0, 0, 0);
      chk("err_cleared", 32'(alloc_err), 0);

      // Release into an empty list: no same-cycle bypass
      release_en[0] = 1'b1; release_preg[0] = 6'd5;
      release_en[1] = 1'b1; release_preg[1] = 6'd7;
      #1;
      chk("nobypass_valid0", 32'(free_valid[0]), 0);
      chk("nobypass_count", 32'(free_count), 0);
      step();
      idle_inputs();
      chk("release_preg0", 32'(free_pregs[0]), 5);
      chk("release_preg1", 32'(free_pregs[1]), 7);
      chk("release_count", 32'(free_count), 2);
      q.push_back(5); q.push_back(7);
      mcycle("rel_pop", 1, 1, 0, 0, 0, 0);

      // Odd count: one left, dual request pops only it and flags an error
      do_reset();
      for (int i = 0; i < 15; i++) mcycle("odd_drain", 1, 1, 0, 0, 0, 0);
      mcycle("odd_single", 1, 0, 0, 0, 0, 0);
      chk("odd_last_preg", 32'(free_pregs[0]), 63);
      chk("odd_valid1", 32'(free_valid[1]), 0);
      mcycle("odd_dual", 1, 1, 0, 0, 0, 0);
      chk("odd_err", 32'(alloc_err), 1);
      chk("odd_count", 32'(free_count), 0);
      mcycle("port1_only", 0, 1, 0, 0, 0, 0);

      // Concurrent pop/push at full occupancy across the pointer wrap
      do_reset();
      for (int i = 0; i < 40; i++) begin
         a = ((2 * i) % 62) + 1;
         mcycle("wrap", 1, 1, 1, 6'(a), 1, 6'(a + 1));
      end
      chk("wrap_count", 32'(free_count), 32);

      // Overflow: at 31 entries, second release is dropped
      mcycle("pre_ovf", 1, 0, 0, 0, 0, 0);
      chk("pre_ovf_count", 32'(free_count), 31);
      mcycle("ovf", 0, 0, 1, 6'd9, 1, 6'd10);
      chk("ovf_count", 32'(free_count), 32);
      chk("ovf_flag", 32'(overflow), 1);

      // p0 releases are ignored silently
      mcycle("pre_p0", 1, 0, 0, 0, 0, 0);
      mcycle("p0", 0, 0, 1, 6'd0, 1, 6'd0);
      chk("p0_count", 32'(free_count), 31);
      chk("p0_sticky_ovf", 32'(overflow), 1);

      // Drain everything; 9 must come out last and 10 never
      for (int i = 0; i < 20 && q.size() > 0; i++)
         mcycle("final_drain", 1, 1, 0, 0, 0, 0);
      chk("final_empty", 32'(free_count), 0);

      // Asynchronous reset mid-operation
      alloc_req[0] = 1'b1; alloc_req[1] = 1'b1;
      release_en[0] = 1'b1; release_preg[0] = 6'd3;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", 32'(free_count), 32);
      chk("async_rst_preg0", 32'(free_pregs[0]), 32);
      chk("async_rst_preg1", 32'(free_pregs[1]), 33);
      chk("async_rst_ovf", 32'(overflow), 0);
      chk("async_rst_err", 32'(alloc_err), 0);
      idle_inputs();
      step();
      rst = 1'b0;
      step();
      chk("post_rst_count", 32'(free_count), 32);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
